// File: rtl/paddle_hit_capture_pkg.sv
// rtl/paddle_hit_capture_pkg.sv - shared game constants for paddle input and rally logic
package paddle_hit_capture_pkg;

  // Player indices, shared with the rally state machine's hits[1:0] input
  localparam int P0 = 0;
  localparam int P1 = 1;
  localparam int NUM_PLAYERS = 2;

  // 10 ms at 100 MHz; the counter must be wide enough to reach DEBOUNCE_CYCLES-1
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int CNT_W_DEFAULT = 20;

endpackage

// File: rtl/paddle_hit_capture_debounce_ch.sv
// rtl/paddle_hit_capture_debounce_ch.sv - one paddle channel: synchroniser, debounce, press edge
module hit_debounce_ch
  import paddle_hit_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;

  // Two-flop synchroniser for the asynchronous button; only r_sync2 is used below
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it disagrees with the stable one for a full window;
  // any agreeing cycle restarts the count so short glitches never get through
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Edge history so a held button produces a single one-cycle press
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stable_d <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
    end
  end

  assign level = r_stable;
  assign press = r_stable & ~r_stable_d;

endmodule

// File: rtl/paddle_hit_capture.sv
// rtl/paddle_hit_capture.sv - two-channel paddle input stage holding pending hit requests
module paddle_hit_capture
  import paddle_hit_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_PLAYERS-1:0] btn_raw,
  input  logic                   step,
  output logic [NUM_PLAYERS-1:0] hits,
  output logic [NUM_PLAYERS-1:0] btn_db
);

  logic [NUM_PLAYERS-1:0] w_press;
  logic [NUM_PLAYERS-1:0] r_hits;

  hit_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_p0 (
    .clock(clock),
    .reset(reset),
    .raw  (btn_raw[P0]),
    .level(btn_db[P0]),
    .press(w_press[P0])
  );

  hit_debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ch_p1 (
    .clock(clock),
    .reset(reset),
    .raw  (btn_raw[P1]),
    .level(btn_db[P1]),
    .press(w_press[P1])
  );

  // Pending requests: step consumes what was presented, a press on the same cycle re-arms
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hits <= '0;
    end else begin
      r_hits <= (r_hits & ~{NUM_PLAYERS{step}}) | w_press;
    end
  end

  assign hits = r_hits;

endmodule

// File: tb/tb_paddle_hit_capture.sv
// tb/tb_paddle_hit_capture.sv - scoreboard bench for paddle_hit_capture
module tb_paddle_hit_capture;

  localparam int D = 8;

  typedef struct {
    int         cyc;
    logic [1:0] val;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] btn_raw;
  logic       step;
  logic [1:0] hits;
  logic [1:0] btn_db;

  int  edge_cnt = 0;
  int  n_tests  = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;
  ev_t hq[$];
  ev_t dq[$];
  logic [1:0] prev_hits;
  logic [1:0] prev_db;

  paddle_hit_capture #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .btn_raw(btn_raw),
    .step   (step),
    .hits   (hits),
    .btn_db (btn_db)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_h(input int c, input logic [1:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    hq.push_back(e);
  endtask

  task automatic push_d(input int c, input logic [1:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    dq.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic pulse_step(input logic [1:0] exp_after);
    step = 1'b1;
    push_h(edge_cnt + 1, exp_after);
    tick(1);
    step = 1'b0;
  endtask

  // Monitor: every change on hits or btn_db must match the next scoreboard entry
  always @(negedge clock) begin
    if (mon_en) begin
      if (hits !== prev_hits) begin
        n_tests++;
        if (hq.size() == 0) begin
          n_fail++;
          $display("FAIL hits_unexpected: got %b at edge %0d, required no change", hits, edge_cnt);
        end else begin
          ev_t e;
          e = hq.pop_front();
          if (e.cyc != edge_cnt || e.val !== hits) begin
            n_fail++;
            $display("FAIL hits_event: got %b at edge %0d, required %b at edge %0d",
                     hits, edge_cnt, e.val, e.cyc);
          end
        end
        prev_hits = hits;
      end
      if (btn_db !== prev_db) begin
        n_tests++;
        if (dq.size() == 0) begin
          n_fail++;
          $display("FAIL btn_db_unexpected: got %b at edge %0d, required no change", btn_db, edge_cnt);
        end else begin
          ev_t e;
          e = dq.pop_front();
          if (e.cyc != edge_cnt || e.val !== btn_db) begin
            n_fail++;
            $display("FAIL btn_db_event: got %b at edge %0d, required %b at edge %0d",
                     btn_db, edge_cnt, e.val, e.cyc);
          end
        end
        prev_db = btn_db;
      end
    end
  end

  initial begin
    int e;
    reset   = 1'b1;
    btn_raw = 2'b00;
    step    = 1'b0;
    tick(3);
    reset = 1'b0;
    check("reset_hits", int'(hits), 0);
    check("reset_btn_db", int'(btn_db), 0);
    prev_hits = 2'b00;
    prev_db   = 2'b00;
    mon_en    = 1'b1;

    // step with nothing pending: no output change expected
    tick(2);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(2);

    // Clean press on channel 0, held long
    e = edge_cnt;
    btn_raw = 2'b01;
    push_d(e + D + 2, 2'b01);
    push_h(e + D + 3, 2'b01);
    tick(50);

    // Consume while still held; btn_db must not move
    pulse_step(2'b00);
    tick(3);
    e = edge_cnt;
    btn_raw = 2'b00;
    push_d(e + D + 2, 2'b00);
    tick(14);

    // Bounce on channel 1: runs of 3 never settle, then steady high
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = (i % 2 == 0);
      tick(3);
    end
    e = edge_cnt;
    btn_raw = 2'b10;
    push_d(e + D + 2, 2'b10);
    push_h(e + D + 3, 2'b10);
    tick(14);

    // Collision: new press on channel 1 arrives with step while hits[1] is pending
    e = edge_cnt;
    btn_raw = 2'b00;
    push_d(e + D + 2, 2'b00);
    tick(14);
    e = edge_cnt;
    btn_raw = 2'b10;
    push_d(e + D + 2, 2'b10);
    tick(D + 2);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    check("collision_hits", int'(hits), 2);
    tick(3);
    pulse_step(2'b00);
    tick(2);
    e = edge_cnt;
    btn_raw = 2'b00;
    push_d(e + D + 2, 2'b00);
    tick(14);

    // Simultaneous press on both channels
    e = edge_cnt;
    btn_raw = 2'b11;
    push_d(e + D + 2, 2'b11);
    push_h(e + D + 3, 2'b11);
    tick(14);
    pulse_step(2'b00);
    tick(2);
    e = edge_cnt;
    btn_raw = 2'b00;
    push_d(e + D + 2, 2'b00);
    tick(14);

    // Reset mid-debounce of channel 0 with channel 1 pending and high
    e = edge_cnt;
    btn_raw = 2'b10;
    push_d(e + D + 2, 2'b10);
    push_h(e + D + 3, 2'b10);
    tick(14);
    e = edge_cnt;
    btn_raw = 2'b11;
    tick(7);
    reset   = 1'b1;
    btn_raw = 2'b01;
    push_h(e + 8, 2'b00);
    push_d(e + 8, 2'b00);
    tick(2);
    reset = 1'b0;
    push_d(e + 10 + D + 1, 2'b01);
    push_h(e + 10 + D + 2, 2'b01);
    tick(14);

    pulse_step(2'b00);
    tick(2);
    e = edge_cnt;
    btn_raw = 2'b00;
    push_d(e + D + 2, 2'b00);
    tick(14);

    check("hits_queue_drained", hq.size(), 0);
    check("btn_db_queue_drained", dq.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
